// File: rtl/div_16by8_seq.sv
// Sequential restoring divider: DW-bit unsigned dividend by VW-bit unsigned divisor,
// one quotient bit per cycle, valid/ready handshake on both sides.
module div_16by8_seq #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [DW-1:0] A,
  input  logic [VW-1:0] B,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          DBZ
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [VW-1:0] b_r;
  logic [VW-1:0] prem_r;
  logic [DW-1:0] qsr_r;
  logic [CW-1:0] cnt_r;
  logic [DW-1:0] q_r;
  logic [VW-1:0] r_r;
  logic          dbz_r;

  logic [VW:0]   p_s;
  logic          ge_s;
  logic [VW-1:0] step_prem_s;
  logic [DW-1:0] step_qsr_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (IN_VALID) begin
          state_nxt_s = (B == {VW{1'b0}}) ? DONE : BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        if (OUT_READY) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // One restoring step. The compare is VW+1 bits wide; the difference is kept
  // at VW bits because a restored remainder is always below the divisor.
  always_comb begin
    p_s         = {prem_r, qsr_r[DW-1]};
    ge_s        = (p_s >= {1'b0, b_r});
    step_prem_s = p_s[VW-1:0];
    if (ge_s) begin
      step_prem_s = p_s[VW-1:0] - b_r;
    end else begin
      step_prem_s = p_s[VW-1:0];
    end
    step_qsr_s = {qsr_r[DW-2:0], ge_s};
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      b_r    <= {VW{1'b0}};
      prem_r <= {VW{1'b0}};
      qsr_r  <= {DW{1'b0}};
      cnt_r  <= {CW{1'b0}};
      q_r    <= {DW{1'b0}};
      r_r    <= {VW{1'b0}};
      dbz_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (IN_VALID) begin
            b_r <= B;
            if (B == {VW{1'b0}}) begin
              q_r   <= {DW{1'b1}};
              r_r   <= A[VW-1:0];
              dbz_r <= 1'b1;
            end else begin
              prem_r <= {VW{1'b0}};
              qsr_r  <= A;
              cnt_r  <= CW'(DW - 1);
            end
          end
        end
        BUSY: begin
          prem_r <= step_prem_s;
          qsr_r  <= step_qsr_s;
          if (cnt_r == {CW{1'b0}}) begin
            q_r   <= step_qsr_s;
            r_r   <= step_prem_s;
            dbz_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          q_r <= q_r;
        end
        default: begin
          q_r <= q_r;
        end
      endcase
    end
  end

  assign IN_READY  = (state_r == IDLE);
  assign OUT_VALID = (state_r == DONE);
  assign Q         = q_r;
  assign R         = r_r;
  assign DBZ       = dbz_r;

endmodule

// File: tb/tb_div_16by8_seq.sv
// Self-checking bench for div_16by8_seq: arithmetic reference model with a
// per-cycle output compare, plus directed literal checks.
module tb_div_16by8_seq;

  localparam int DW = 16;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          IN_VALID;
  logic          IN_READY;
  logic [DW-1:0] A;
  logic [VW-1:0] B;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [DW-1:0] Q;
  logic [VW-1:0] R;
  logic          DBZ;

  div_16by8_seq #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst(rst),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .A(A), .B(B),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .Q(Q), .R(R), .DBZ(DBZ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    int            acc;
  } op_t;

  op_t pend[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  bit  prev_ov = 1'b0;

  function automatic logic [24:0] model(input logic [15:0] a, input logic [7:0] b);
    logic [15:0] qq;
    logic [15:0] rr;
    if (b == 8'd0) return {1'b1, 16'hFFFF, a[7:0]};
    qq = a / {8'd0, b};
    rr = a % {8'd0, b};
    return {1'b0, qq, rr[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, got, got, exp, exp, cyc);
    end
  endtask

  // Track accepts and output handshakes at each rising edge
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      pend.delete();
    end else begin
      if (IN_VALID && IN_READY) pend.push_back('{A, B, cyc});
      if (OUT_VALID && OUT_READY && pend.size() > 0) void'(pend.pop_front());
    end
  end

  // Compare outputs against the model on every cycle a result is presented
  initial forever begin
    @(negedge clk);
    if (!rst && OUT_VALID) begin
      if (pend.size() == 0) begin
        check("spurious_out_valid", {31'd0, OUT_VALID}, 32'd0);
      end else begin
        check("result_dbz_q_r", {7'd0, DBZ, Q, R}, {7'd0, model(pend[0].a, pend[0].b)});
        if (!prev_ov)
          check("latency", cyc - pend[0].acc, (pend[0].b == 8'd0) ? 32'd0 : DW);
      end
    end
    prev_ov = OUT_VALID;
  end

  task automatic send(input logic [15:0] a, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    A = a; B = b; IN_VALID = 1'b1;
    while (!IN_READY && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!IN_READY) check("accept_timeout", {31'd0, IN_READY}, 32'd1);
    @(posedge clk);
    #1;
    IN_VALID = 1'b0;
    A = 16'($urandom);
    B = 8'($urandom);
  endtask

  task automatic wait_out();
    int n = 0;
    @(negedge clk);
    while (!OUT_VALID && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!OUT_VALID) check("out_valid_timeout", {31'd0, OUT_VALID}, 32'd1);
    #1;
  endtask

  task automatic expect_res(input logic [15:0] q, input logic [7:0] r, input logic d);
    wait_out();
    check("lit_q", {16'd0, Q}, {16'd0, q});
    check("lit_r", {24'd0, R}, {24'd0, r});
    check("lit_dbz", {31'd0, DBZ}, {31'd0, d});
    @(posedge clk);
    #1;
    check("in_ready_after_hs", {31'd0, IN_READY}, 32'd1);
    check("out_valid_after_hs", {31'd0, OUT_VALID}, 32'd0);
  endtask

  initial begin
    int n;
    logic [15:0] ra;
    logic [7:0]  rb;
    rst = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1; A = 16'd0; B = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, IN_READY}, 32'd1);
    check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_q", {16'd0, Q}, 32'd0);
    check("rst_r", {24'd0, R}, 32'd0);
    check("rst_dbz", {31'd0, DBZ}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    send(16'd1000, 8'd7);   expect_res(16'd142, 8'd6, 1'b0);
    send(16'd65535, 8'd1);  expect_res(16'd65535, 8'd0, 1'b0);
    send(16'd65535, 8'd255); expect_res(16'd257, 8'd0, 1'b0);
    send(16'd100, 8'd200);  expect_res(16'd0, 8'd100, 1'b0);

    send(16'd5, 8'd0);      expect_res(16'hFFFF, 8'h05, 1'b1);
    send(16'd9, 8'd3);      expect_res(16'd3, 8'd0, 1'b0);

    // Backpressure with a new request waiting
    OUT_READY = 1'b0;
    send(16'd50000, 8'd13);
    wait_out();
    A = 16'd1234; B = 8'd56; IN_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("bp_out_valid", {31'd0, OUT_VALID}, 32'd1);
      check("bp_in_ready", {31'd0, IN_READY}, 32'd0);
      check("bp_q", {16'd0, Q}, 32'd3846);
      check("bp_r", {24'd0, R}, 32'd2);
    end
    OUT_READY = 1'b1;
    @(posedge clk);
    #1;
    check("bp_in_ready_after_hs", {31'd0, IN_READY}, 32'd1);
    @(posedge clk);
    #1;
    IN_VALID = 1'b0;
    check("bp_pending_accept", pend.size(), 32'd1);
    expect_res(16'd22, 8'd2, 1'b0);

    // Reset while busy
    send(16'd1000, 8'd3);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", {31'd0, IN_READY}, 32'd1);
    check("mid_rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("mid_rst_q", {16'd0, Q}, 32'd0);
    check("mid_rst_r", {24'd0, R}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(16'd255, 8'd16);   expect_res(16'd15, 8'd15, 1'b0);

    // Random operands with random output stalls
    for (int k = 0; k < 2000; k++) begin
      ra = 16'($urandom);
      rb = 8'($urandom_range(1, 255));
      send(ra, rb);
      n = 0;
      while (n < 200) begin
        @(negedge clk);
        OUT_READY = ($urandom_range(0, 3) != 0);
        if (OUT_VALID && OUT_READY) break;
        n++;
      end
      if (n >= 200) check("rand_timeout", {31'd0, OUT_VALID}, 32'd1);
      @(posedge clk);
      #1;
    end

    OUT_READY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pending_empty", pend.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
